// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler: FSM encoding and width helper.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_ptr, first requester wins.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any_req
);

  int                 idx;
  logic [NUM_REQ-1:0] req_sh;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    req_sh  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      req_sh = req >> idx;
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        winner  = NUM_REQ'(1) << idx;
        win_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte FIFOs with round-robin grants
// and bounded bursts; one byte in flight at a time.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rdata,
  output logic [NUM_REQ-1:0]            req_rd,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t                        state, state_d;
  logic [NUM_REQ-1:0]            grant_q, req_vec, arb_winner, empty_sh;
  logic [PTR_W-1:0]              owner, last_ptr, arb_idx;
  logic [CNT_W-1:0]              burst_cnt, cnt_inc;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_sh;
  logic                          arb_any, owner_ready, others_ready;
  logic                          take_grant, continue_burst, wrap_burst, release_grant;

  assign req_vec = ~req_empty & {NUM_REQ{en}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_vec),
    .last_ptr (last_ptr),
    .winner   (arb_winner),
    .win_idx  (arb_idx),
    .any_req  (arb_any)
  );

  assign empty_sh     = req_empty >> owner;
  assign owner_ready  = en & ~empty_sh[0];
  assign others_ready = |(req_vec & ~grant_q);
  assign cnt_inc      = burst_cnt + 1'b1;
  assign rdata_sh     = req_rdata >> (owner * DATA_WIDTH);

  always_comb begin
    state_d        = state;
    take_grant     = 1'b0;
    continue_burst = 1'b0;
    wrap_burst     = 1'b0;
    release_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          take_grant = 1'b1;
          state_d    = READ;
        end
      end
      READ:  state_d = LATCH;
      LATCH: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (owner_ready && (cnt_inc < BURST_MAX)) begin
            continue_burst = 1'b1;
            state_d        = READ;
          end else if (owner_ready && (cnt_inc == BURST_MAX) && !others_ready) begin
            // Nobody else is waiting, so the owner keeps the line with a fresh burst.
            wrap_burst = 1'b1;
            state_d    = READ;
          end else begin
            release_grant = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q   <= '0;
      owner     <= '0;
      last_ptr  <= PTR_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      tx_data   <= '0;
    end else begin
      if (take_grant) begin
        grant_q   <= arb_winner;
        owner     <= arb_idx;
        burst_cnt <= '0;
      end
      if (state == LATCH) tx_data <= rdata_sh[DATA_WIDTH-1:0];
      if (continue_burst) burst_cnt <= cnt_inc;
      if (wrap_burst) burst_cnt <= '0;
      if (release_grant) begin
        grant_q   <= '0;
        last_ptr  <= owner;
        burst_cnt <= '0;
      end
    end
  end

  assign req_rd   = (state == READ) ? grant_q : '0;
  assign tx_start = (state == START);
  assign grant    = grant_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (MAX_BURST=4 and 1) fed by FIFO and UART models,
// transmitted bytes checked in order against a scoreboard of {source, byte}.
module tb_uart_tx_scheduler;

  localparam int DONE_LAT = 6;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  empty [2];
  logic [15:0] rdata [2];
  logic [1:0]  rd    [2];
  logic        start [2];
  logic [7:0]  data  [2];
  logic        done  [2];
  logic [1:0]  grant [2];
  logic        busy  [2];

  logic [7:0]  fq [4][$];
  logic [8:0]  sb [2][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done [2];
  bit gap_en [2];
  int rd_count [2];
  int ucnt [2];
  int r0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .en(en), .req_empty(empty[0]), .req_rdata(rdata[0]),
    .req_rd(rd[0]), .tx_start(start[0]), .tx_data(data[0]), .tx_done(done[0]),
    .grant(grant[0]), .busy(busy[0])
  );

  uart_tx_scheduler #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .en(en), .req_empty(empty[1]), .req_rdata(rdata[1]),
    .req_rd(rd[1]), .tx_start(start[1]), .tx_data(data[1]), .tx_done(done[1]),
    .grant(grant[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART model: tx_done pulses DONE_LAT cycles after tx_start.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      done[d] <= 1'b0;
      if (!rst) ucnt[d] <= 0;
      else if (start[d]) ucnt[d] <= DONE_LAT;
      else if (ucnt[d] > 0) begin
        ucnt[d] <= ucnt[d] - 1;
        if (ucnt[d] == 1) done[d] <= 1'b1;
      end
    end
  end

  // FIFO model: pop mid-cycle of the rd strobe, data valid the following cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        int k;
        k = d * 2 + i;
        if (rd[d][i]) begin
          chk("pop_nonempty", 32'(fq[k].size() > 0), 32'd1);
          if (fq[k].size() > 0) rdata[d][i*8 +: 8] = fq[k].pop_front();
          empty[d][i] = (fq[k].size() == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    logic [1:0] eg;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rd[d] != 2'b00) begin
        rd_count[d]++;
        chk("rd_matches_grant", 32'(rd[d]), 32'(grant[d]));
        chk("rd_start_exclusive", 32'(start[d]), 32'd0);
      end
      if (start[d]) begin
        chk("tx_expected", 32'(sb[d].size() > 0), 32'd1);
        if (sb[d].size() > 0) begin
          e  = sb[d].pop_front();
          eg = 2'b01 << e[8];
          chk("tx_data", 32'(data[d]), 32'(e[7:0]));
          chk("tx_grant", 32'(grant[d]), 32'(eg));
        end
        if (gap_en[d] && last_done[d] >= 0) chk("burst_gap", 32'(cyc - last_done[d]), 32'd3);
      end
      if (done[d]) last_done[d] = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int d, input int i, input logic [7:0] b);
    fq[d*2+i].push_back(b);
    empty[d][i] = 1'b0;
  endtask

  task automatic expect_tx(input int d, input int i, input logic [7:0] b);
    logic src;
    src = (i != 0);
    sb[d].push_back({src, b});
  endtask

  task automatic wait_start(input int d, input int budget);
    int n;
    n = 0;
    while (!start[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_drained(input int d, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy[d] || sb[d].size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", 32'(grant[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_tx_data", 32'(data[d]), 32'd0);
      chk("rst_req_rd", 32'(rd[d]), 32'd0);
      chk("rst_tx_start", 32'(start[d]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      empty[d] = 2'b11;
      rdata[d] = 16'h0000;
      last_done[d] = -1;
      gap_en[d] = 1'b0;
      rd_count[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b1;

    // Reset held three cycles while a byte is in WAIT; the second byte follows afterwards.
    fill(0, 0, 8'h77); fill(0, 0, 8'h78);
    expect_tx(0, 0, 8'h77); expect_tx(0, 0, 8'h78);
    wait_start(0, 50);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b1;
    wait_drained(0, 200);

    // Single byte with exact latency.
    fill(0, 0, 8'h41);
    expect_tx(0, 0, 8'h41);
    @(negedge clk);
    chk("single_rd", 32'(rd[0]), 32'd1);
    @(negedge clk);
    chk("single_rd_once", 32'(rd[0]), 32'd0);
    chk("single_no_early_start", 32'(start[0]), 32'd0);
    @(negedge clk);
    chk("single_start_lat3", 32'(start[0]), 32'd1);
    chk("single_data", 32'(data[0]), 32'h41);
    wait_drained(0, 200);
    chk("single_grant_idle", 32'(grant[0]), 32'd0);

    // Round robin with MAX_BURST=1.
    fill(1, 0, 8'h10); fill(1, 0, 8'h11); fill(1, 1, 8'h20); fill(1, 1, 8'h21);
    expect_tx(1, 0, 8'h10); expect_tx(1, 1, 8'h20);
    expect_tx(1, 0, 8'h11); expect_tx(1, 1, 8'h21);
    wait_drained(1, 300);
    chk("rr_grant_idle", 32'(grant[1]), 32'd0);

    // Burst of 4 then rotation, starting from a fresh reset so FIFO0 wins first.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r0 = rd_count[0];
    for (int j = 0; j < 6; j++) fill(0, 0, 8'hA0 + 8'(j));
    for (int j = 0; j < 2; j++) fill(0, 1, 8'hB0 + 8'(j));
    for (int j = 0; j < 4; j++) expect_tx(0, 0, 8'hA0 + 8'(j));
    for (int j = 0; j < 2; j++) expect_tx(0, 1, 8'hB0 + 8'(j));
    for (int j = 4; j < 6; j++) expect_tx(0, 0, 8'hA0 + 8'(j));
    wait_drained(0, 400);
    chk("burst_pops", 32'(rd_count[0] - r0), 32'd8);

    // Lone owner keeps the line past MAX_BURST with no idle gap.
    gap_en[0] = 1'b1;
    last_done[0] = -1;
    for (int j = 0; j < 6; j++) begin
      fill(0, 0, 8'hC0 + 8'(j));
      expect_tx(0, 0, 8'hC0 + 8'(j));
    end
    wait_drained(0, 400);
    gap_en[0] = 1'b0;

    // en dropped during WAIT: byte completes, nothing more popped until en returns.
    r0 = rd_count[0];
    fill(0, 0, 8'h55); fill(0, 0, 8'h56);
    expect_tx(0, 0, 8'h55);
    wait_start(0, 50);
    en = 1'b0;
    repeat (40) @(negedge clk);
    chk("en_off_pops", 32'(rd_count[0] - r0), 32'd1);
    chk("en_off_busy", 32'(busy[0]), 32'd0);
    chk("en_off_grant", 32'(grant[0]), 32'd0);
    chk("en_off_queue_left", 32'(sb[0].size()), 32'd0);
    en = 1'b1;
    expect_tx(0, 0, 8'h56);
    wait_drained(0, 200);
    chk("en_on_pops", 32'(rd_count[0] - r0), 32'd2);

    // FIFO runs dry mid-burst.
    r0 = rd_count[0];
    fill(0, 0, 8'h61); fill(0, 0, 8'h62);
    expect_tx(0, 0, 8'h61); expect_tx(0, 0, 8'h62);
    wait_drained(0, 200);
    repeat (10) @(negedge clk);
    chk("dry_pops", 32'(rd_count[0] - r0), 32'd2);
    chk("dry_empty", 32'(empty[0]), 32'd3);
    chk("dry_busy", 32'(busy[0]), 32'd0);

    chk("sb0_drained", 32'(sb[0].size()), 32'd0);
    chk("sb1_drained", 32'(sb[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
